// File: rtl/mem_hs.sv
// Single-port word memory behind a valid/ready request channel; reads return
// through a 2-entry response FIFO with 1-cycle latency, plus usage counters.
module mem_hs #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_err;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [CNT_WIDTH-1:0]  r_wr_count;
  logic [CNT_WIDTH-1:0]  r_err_count;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [1:0]            w_count_nxt;

  assign w_in_range = ({1'b0, req_addr} < DEPTH_L);
  assign w_accept   = req_valid & r_req_ready & ~rst;
  assign w_push     = w_accept & ~req_write;
  assign w_pop      = r_rsp_valid & rsp_ready;

  // Read data for a new push; out-of-range reads return zero.
  always_comb begin
    w_rd_data = {DATA_WIDTH{1'b0}};
    if (w_in_range) begin
      w_rd_data = r_mem[req_addr];
    end else begin
      w_rd_data = {DATA_WIDTH{1'b0}};
    end
  end

  // FIFO occupancy after this edge.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Memory array: not reset, written only by accepted in-range writes.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && w_in_range) begin
      r_mem[req_addr] <= req_wdata;
    end
  end

  // Response FIFO; handshake flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_data[0] <= {DATA_WIDTH{1'b0}};
      r_fifo_data[1] <= {DATA_WIDTH{1'b0}};
      r_fifo_err     <= 2'b00;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
      r_req_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_rd_data;
        r_fifo_err[r_wr_ptr]  <= ~w_in_range;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt < 2'd2);
      r_rsp_valid <= (w_count_nxt != 2'd0);
    end
  end

  // Activity counters: read/write wrap, error saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count  <= {CNT_WIDTH{1'b0}};
      r_wr_count  <= {CNT_WIDTH{1'b0}};
      r_err_count <= {CNT_WIDTH{1'b0}};
    end else begin
      if (w_accept && !req_write) begin
        r_rd_count <= r_rd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_accept && req_write) begin
        r_wr_count <= r_wr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (w_accept && !w_in_range && (r_err_count != {CNT_WIDTH{1'b1}})) begin
        r_err_count <= r_err_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_fifo_data[r_rd_ptr];
  assign rsp_err   = r_fifo_err[r_rd_ptr];
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;
  assign err_count = r_err_count;

endmodule

// File: doc/mem_hs.md
MEM_HS -- requirements
Module: mem_hs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, giving the address bus width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the data bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, giving the number of words implemented; legal range is 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, giving the width of the status counters.
REQ-005 clk  input  1  the single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req_valid  input  1  a request is presented.
REQ-008 req_ready  output  1  the block can accept a request this cycle.
REQ-009 req_write  input  1  1 = write request, 0 = read request.
REQ-010 req_addr  input  ADDR_WIDTH  request word address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 rsp_valid  output  1  a read response is presented.
REQ-013 rsp_ready  input  1  the consumer accepts the response this cycle.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data of the head response.
REQ-015 rsp_err  output  1  the head response is for an out-of-range address.
REQ-016 rd_count  output  CNT_WIDTH  number of accepted reads, wrapping.
REQ-017 wr_count  output  CNT_WIDTH  number of accepted writes, wrapping.
REQ-018 err_count  output  CNT_WIDTH  number of accepted out-of-range requests (read or write), saturating at all-ones.

Function
REQ-019 A request SHALL be accepted exactly on a rising edge where req_valid and req_ready are both 1.
REQ-020 An accepted write with req_addr < DEPTH SHALL update mem[req_addr] with req_wdata at that edge; writes produce no response.
REQ-021 An accepted write with req_addr >= DEPTH SHALL leave memory unchanged and increment err_count.
REQ-022 An accepted read SHALL push one entry {data, err} into a 2-entry response FIFO at that edge: data = mem[req_addr], err = 0 if req_addr < DEPTH; data = 0, err = 1 (and err_count increments) otherwise.
REQ-023 Read latency SHALL be 1 cycle: rsp_valid is 1 in the cycle after acceptance if the FIFO was empty.
REQ-024 rsp_valid SHALL be 1 whenever FIFO count != 0; rsp_rdata and rsp_err SHALL reflect the head entry and remain stable while rsp_valid=1 and rsp_ready=0.
REQ-025 A response SHALL pop on a rising edge where rsp_valid and rsp_ready are both 1.
REQ-026 req_ready SHALL be 1 iff FIFO count < 2, registered-state only, with no combinational path from rsp_ready or req_valid; this applies to reads and writes alike.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve response order.
REQ-028 Responses SHALL be returned strictly in request acceptance order.
REQ-029 A read accepted on the edge after a write to the same address SHALL return the newly written data.
REQ-030 rd_count and wr_count SHALL increment by 1 per accepted read/write (including out-of-range) and wrap from all-ones to 0.
REQ-031 err_count SHALL hold at all-ones once reached.

Reset
REQ-032 With rst=1 at a rising edge: FIFO count=0, rsp_valid=0, req_ready=1, rsp_rdata=0, rsp_err=0, rd_count=wr_count=err_count=0.
REQ-033 Reset SHALL NOT clear memory contents; a request presented while rst=1 SHALL NOT be accepted and SHALL NOT modify memory.
REQ-034 Reset asserted while responses are pending SHALL discard them; no response from before reset appears afterward.

Verification
REQ-035 Write 0xA5 to addr 3, then read addr 3 with rsp_ready=1 -> rsp_valid next cycle, rsp_rdata=0xA5, rsp_err=0, wr_count=1, rd_count=1.
REQ-036 rsp_ready=0, issue reads of addr 1,2,3 back-to-back -> first two accepted, req_ready=0 on third; raise rsp_ready -> responses for 1,2,3 in order, third accepted after first pop.
REQ-037 DEPTH=20: write addr 25 then read addr 25 -> memory unchanged, response rsp_err=1, rsp_rdata=0, err_count=2.
REQ-038 Count=1 with rsp_ready=1 and new read accepted same cycle -> count stays 1, next head is the new read's data.
REQ-039 Two responses pending, assert rst one cycle -> rsp_valid=0, req_ready=1, counters 0; reread prior written address returns old data.
REQ-040 CNT_WIDTH=4: 16 accepted writes -> wr_count wraps to 0; 16 out-of-range reads -> err_count holds 15.
